// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the instruction-word layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // R/I-type field layout, MSB first
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

endpackage

// File: rtl/riscv_regfile.sv
// 32 x XLEN integer register file, 2 read / 1 write, x0 hardwired to zero.
// Latency: combinational read with write-through bypass; write lands on the clock edge.
// Backpressure: none, every write strobe is taken.
// Ports: i_raddr1/i_raddr2 -> o_rdata1/o_rdata2; i_we/i_waddr/i_wdata write port.
module riscv_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_regs [32];
    logic            w_hit1;
    logic            w_hit2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Same-cycle write forwards to the reader so a waiting consumer can issue on the writeback cycle
    assign w_hit1 = i_we && (i_waddr == i_raddr1);
    assign w_hit2 = i_we && (i_waddr == i_raddr2);

    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : (w_hit1 ? i_wdata : r_regs[i_raddr1]);
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : (w_hit2 ? i_wdata : r_regs[i_raddr2]);

endmodule

// File: rtl/riscv_decode_issue.sv
// Decode OP/OP-IMM, read operands, scoreboard hazards and issue to the ALU.
// Latency: accepted at edge N, ex_valid high after edge N; 1 instr/cycle without hazards.
// Backpressure: instr_ready low while a held issue is not consumed or a source/dest is busy.
// Ports: instr_* fetch handshake; ex_* / op1 / op2 / ALU_op / ALU_op_ext / rd issue;
//        wb_* result writeback; illegal one-cycle pulse per rejected instruction.
module riscv_decode_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [2:0]      ALU_op,
    output logic [6:0]      ALU_op_ext,
    output logic [4:0]      rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    instr_t          w_ins;
    logic            w_is_op;
    logic            w_is_imm;
    logic            w_is_shift;
    logic            w_f7_ok;
    logic            w_legal;
    logic [31:0]     w_clr_mask;
    logic [31:0]     w_busy_eff;
    logic [31:0]     w_busy_nxt;
    logic            w_hazard;
    logic            w_accept;
    logic            w_issue;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic [XLEN-1:0] w_op2;
    logic [6:0]      w_ext;

    logic [31:0]     r_busy;
    logic            r_ex_valid;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [2:0]      r_alu_op;
    logic [6:0]      r_alu_ext;
    logic [4:0]      r_rd;
    logic            r_illegal;

    assign w_ins      = instr_t'(instr);
    assign w_is_op    = (w_ins.opcode == OPC_OP);
    assign w_is_imm   = (w_ins.opcode == OPC_OP_IMM);
    assign w_is_shift = (w_ins.funct3 == F3_SLL) || (w_ins.funct3 == F3_SR);

    // ALT funct7 is only meaningful for SUB/SRA (OP) and SRAI (OP-IMM)
    assign w_f7_ok = (w_ins.funct7 == F7_BASE) ||
                     ((w_ins.funct7 == F7_ALT) &&
                      ((w_ins.funct3 == F3_SR) || (w_is_op && (w_ins.funct3 == F3_ADD))));

    assign w_legal = (w_is_op && w_f7_ok) || (w_is_imm && (!w_is_shift || w_f7_ok));

    riscv_regfile #(.XLEN(XLEN)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (w_ins.rs1),
        .i_raddr2 (w_ins.rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (wb_valid),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data)
    );

    // A register retiring this cycle is already free for the hazard check
    assign w_clr_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign w_busy_eff = r_busy & ~w_clr_mask;

    // Illegal encodings bypass the hazard check; busy bit 0 is never set so x0 never stalls
    assign w_hazard = w_legal &&
                      (w_busy_eff[w_ins.rs1] ||
                       (w_is_op && w_busy_eff[w_ins.rs2]) ||
                       w_busy_eff[w_ins.rd]);

    assign instr_ready = rst_n && (!r_ex_valid || ex_ready) && !w_hazard;
    assign w_accept    = instr_valid && instr_ready;
    assign w_issue     = w_accept && w_legal;

    // Shift immediates carry funct7 in [31:25]; other immediates keep ext at 0 so ADDI never looks like SUB
    always_comb begin
        w_op2 = w_rdata2;
        w_ext = w_ins.funct7;
        if (w_is_imm) begin
            if (w_is_shift) begin
                w_op2 = {{(XLEN-5){1'b0}}, instr[24:20]};
            end else begin
                w_op2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
                w_ext = F7_BASE;
            end
        end
    end

    // Set wins over a same-cycle clear of the same register
    always_comb begin
        w_busy_nxt = r_busy & ~w_clr_mask;
        if (w_issue) begin
            w_busy_nxt[w_ins.rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_ex_valid <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_alu_op   <= '0;
            r_alu_ext  <= '0;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_illegal <= w_accept && !w_legal;
            if (w_issue) begin
                r_ex_valid <= 1'b1;
                r_op1      <= w_rdata1;
                r_op2      <= w_op2;
                r_alu_op   <= w_ins.funct3;
                r_alu_ext  <= w_ext;
                r_rd       <= w_ins.rd;
            end else if (ex_ready) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign ex_valid   = r_ex_valid;
    assign op1        = r_op1;
    assign op2        = r_op2;
    assign ALU_op     = r_alu_op;
    assign ALU_op_ext = r_alu_ext;
    assign rd         = r_rd;
    assign illegal    = r_illegal;

endmodule

// File: doc/riscv_decode_issue.md
# riscv_decode_issue

Decode-and-issue stage that feeds the integer ALU. It accepts 32-bit RV32I instructions over a valid/ready handshake and decodes OP and OP-IMM encodings into `ALU_op`/`ALU_op_ext` plus two operands. It reads operands from an internal register file, stalls read-after-write and write-after-write hazards with a busy-bit scoreboard, and retires ALU results through a writeback port. It sits between fetch and the execute stage of the no-pipeline core.

## Interface
- `XLEN`, 32, datapath and register width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: fetch offers `instr`.
- `instr_ready` out 1: stage accepts `instr` this cycle.
- `instr` in 32: RV32I instruction word.
- `ex_valid` out 1: issued operation is held on the outputs.
- `ex_ready` in 1: execute consumes the issued operation.
- `op1` out XLEN: rs1 value.
- `op2` out XLEN: rs2 value or immediate.
- `ALU_op` out 3: funct3.
- `ALU_op_ext` out 7: funct7 qualifier (0100000 selects SUB/SRA).
- `rd` out 5: destination register.
- `wb_valid` in 1: writeback strobe.
- `wb_rd` in 5: writeback register.
- `wb_data` in XLEN: writeback value.
- `illegal` out 1: one-cycle pulse when an undecodable instruction is consumed.

## Operation
- **Register file:** 32 x XLEN, all registers reset to 0. x0 reads 0, and writes to x0 are ignored. When `wb_valid` is high and `wb_rd` equals a read address in the same cycle, the read returns `wb_data` (write-through bypass).
- **OP (0110011):**
  - `op1`=x[rs1], `op2`=x[rs2], `ALU_op`=funct3, `ALU_op_ext`=funct7.
  - Legal funct7: 0000000 with any funct3; 0100000 only with funct3 000 or 101.
- **OP-IMM (0010011):**
  - `op1`=x[rs1], `ALU_op`=funct3.
  - funct3 001/101: `op2`=zero-extended `instr[24:20]` and `ALU_op_ext`=`instr[31:25]`. Legal values are 0000000, and 0100000 only for 101.
  - All other funct3: `op2`=sign-extended `instr[31:20]` and `ALU_op_ext`=0. A negative ADDI immediate must never become SUB.
- **Illegal:** any other opcode, or any illegal funct7 combination.
  - The instruction is consumed without a hazard check.
  - It is not issued and the scoreboard is untouched.
  - `illegal` pulses high for one cycle after the accepting edge.
- **Scoreboard:** one busy bit per register; bit 0 is always 0.
  - Issue sets busy[rd] for rd≠0.
  - `wb_valid` clears busy[wb_rd].
  - If both hit the same register in one cycle, the set wins.
- **Hazard:** a legal instruction stalls while any of these is busy: rs1, rs2 (OP only), or rd (rd≠0). A register being cleared by `wb_valid` in the same cycle counts as not busy.
- **Ready:** `instr_ready` = (!`ex_valid` || `ex_ready`) && !hazard. `instr_ready` may depend on `instr`.
- **Writeback to a non-busy register:** the register is still written and no error is raised.

## Timing
- **Reset values:** `instr_ready`=0 during reset. `ex_valid`=0; `op1`, `op2`, `ALU_op`, `ALU_op_ext`, `rd`=0; `illegal`=0. All busy bits are cleared.
- **Latency:** an instruction accepted at edge N appears with `ex_valid`=1 after edge N. Throughput is 1 per cycle when there are no hazards and `ex_ready`=1.
- **Output stability:** outputs hold stable while `ex_valid` && !`ex_ready`. `ex_valid` drops after a consuming edge that has no new accept.
- **Dependent pair:** the second instruction stalls until the cycle in which `wb_valid` for the first instruction's rd is high. It is accepted in that cycle, and its operand is the bypassed `wb_data`.
- **Reset mid-operation:** `rst_n` low discards the held issue and clears the scoreboard and register file immediately.

## Structure
- **Shared package `riscv_pkg`:**
  - `OPC_OP`=7'b0110011, `OPC_OP_IMM`=7'b0010011.
  - `F7_BASE`=7'b0000000, `F7_ALT`=7'b0100000.
  - funct3 constants: ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SR=101, OR=110, AND=111.
- **Sub-module `riscv_regfile`:** 2 read ports, 1 write port, x0 hardwired to 0, write-through bypass, async active-low reset. Decode, scoreboard and the output register stay in the top level.

## Test plan
- Reset, then `addi x1,x0,-5` (0xFFB00093) → `ALU_op`=000, `ALU_op_ext`=0, `op2`=0xFFFFFFFB, `rd`=1, `ex_valid` one cycle after accept.
- `srai x2,x1,3` (0x4030D113) after x1 holds 0x80000000 → `ALU_op`=101, `ALU_op_ext`=0100000, `op2`=3.
- `add x3,x1,x2` issued, then `sub x4,x3,x1` → second instruction stalls with `instr_ready`=0 until `wb_valid`, `wb_rd`=3, `wb_data`=0x10. It is accepted in that cycle with `op1`=0x10.
- Hold `ex_ready`=0 for 3 cycles after an issue → all outputs are stable and `instr_ready`=0. Raise `ex_ready` → the next instruction issues back-to-back.
- Opcode 0x0000007F, then `add` with funct7=0000001 → each instruction is consumed, `illegal` pulses for 1 cycle, `ex_valid` stays 0 and no busy bit is set.
- Assert `rst_n`=0 while `ex_valid`=1 and x5 is busy → `ex_valid`=0 immediately. After release, an instruction reading x5 issues without stalling and with `op1`=0.
